fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 16'h3000, is the PC value loaded on reset.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable_updatePC  input  1  request to advance or redirect the PC this cycle.
REQ-005 enable_fetch  input  1  permission to issue instruction-memory reads.
REQ-006 br_taken  input  1  qualifies enable_updatePC; selects taddr over pc+1.
REQ-007 taddr  input  16  branch or jump target address.
REQ-008 imem_ready  input  1  instruction memory completes the outstanding read this cycle.
REQ-009 pc  output  16  address of the current fetch; registered.
REQ-010 npc  output  16  pc+1, combinational from pc.
REQ-011 imem_rd  output  1  instruction-memory read strobe; registered state decode.
REQ-012 fetch_valid  output  1  one-cycle pulse: instruction at pc returned this cycle.
REQ-013 update_pending  output  1  a PC update is buffered behind an outstanding read.

Function
REQ-014 npc SHALL equal pc+1 modulo 2^16; 16'hFFFF wraps to 16'h0000.
REQ-015 FSM states SHALL be IDLE and REQ; imem_rd SHALL be 1 exactly in REQ.
REQ-016 IDLE->REQ on the clock edge where enable_fetch=1; otherwise the FSM stays in IDLE.
REQ-017 In REQ with imem_ready=1: fetch_valid=1 in that cycle; next state is REQ if enable_fetch=1, else IDLE.
REQ-018 In REQ with imem_ready=0: the FSM stays in REQ regardless of enable_fetch; fetch_valid=0.
REQ-019 fetch_valid SHALL be 0 in IDLE.
REQ-020 Target rule: target = taddr if br_taken=1, else base+1. base = pend_target if update_pending=1, else pc.
REQ-021 Update is immediate (pc <= target at the next edge) when enable_updatePC=1 and (state=IDLE or imem_ready=1).
REQ-022 Update is deferred when enable_updatePC=1, state=REQ and imem_ready=0: pend_target <= target; update_pending <= 1; pc is unchanged.
REQ-023 pc SHALL NOT change while a read is outstanding (state=REQ, imem_ready=0).
REQ-024 On the edge where imem_ready=1 and update_pending=1:
  - with enable_updatePC=0: pc <= pend_target;
  - with enable_updatePC=1: pc <= target per REQ-020;
  - update_pending clears in both cases.
REQ-025 A new deferred update while update_pending=1 SHALL overwrite pend_target per REQ-020. Only one pending slot exists.
REQ-026 br_taken SHALL be ignored when enable_updatePC=0.
REQ-027 With enable_fetch=0 and state=IDLE, pc updates still apply immediately.
REQ-028 update_pending SHALL be driven directly from the pending flag register.

Reset
REQ-029 Asserting reset SHALL asynchronously force:
  - pc=RESET_PC, hence npc=RESET_PC+1;
  - state=IDLE, hence imem_rd=0;
  - fetch_valid=0, update_pending=0, pend_target=0.
REQ-030 Reset mid-request SHALL abandon the outstanding read and discard any pending update.
REQ-031 On the first edge after reset deasserts, behaviour SHALL follow REQ-016 and REQ-021.

Structure
REQ-032 Shared package fetch_ctrl_pkg SHALL hold:
  - the FSM state enum (IDLE, REQ);
  - localparam PC_WIDTH=16;
  - localparam DEFAULT_RESET_PC=16'h3000.
REQ-033 The design SHALL be a single module with no sub-modules. Target-select logic is one combinational block shared by the immediate and deferred paths.

Verification
REQ-034 Reset then enable_fetch=1, imem_ready=1, enable_updatePC=1, br_taken=0 for 3 cycles -> pc 3000,3001,3002,3003; fetch_valid high from the second cycle.
REQ-035 pc=16'hFFFF, enable_updatePC=1, br_taken=0 -> pc=0000 and npc=0001.
REQ-036 In REQ with imem_ready=0, pulse enable_updatePC with br_taken=1, taddr=16'h4000:
  - update_pending=1 and pc held;
  - when imem_ready=1, pc becomes 4000 and update_pending clears.
REQ-037 While pending=4000, issue a deferred update with br_taken=0 -> pend_target=4001; on imem_ready, pc=4001.
REQ-038 Assert reset asynchronously mid-REQ with pending set -> imem_rd, fetch_valid and update_pending go 0, and pc=3000, all without waiting for a clock edge.
REQ-039 enable_fetch=0 throughout with updates applied -> imem_rd stays 0, fetch_valid stays 0, and pc advances per update.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the FSM state encoding, the PC width and the default reset PC.
package fetch_ctrl_pkg;

  localparam int PC_WIDTH = 16;
  localparam logic [PC_WIDTH-1:0] DEFAULT_RESET_PC = 16'h3000;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_e;

  // Sequential successor; wraps naturally at the top of the address space.
  function automatic logic [PC_WIDTH-1:0] pc_inc(input logic [PC_WIDTH-1:0] p);
    return p + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Control/handshake bundle between the fetch controller and its pipeline
// and instruction-memory neighbours.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic                enable_updatePC;
  logic                enable_fetch;
  logic                br_taken;
  logic [PC_WIDTH-1:0] taddr;
  logic                imem_ready;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] npc;
  logic                imem_rd;
  logic                fetch_valid;
  logic                update_pending;

  modport slave (
    input  enable_updatePC, enable_fetch, br_taken, taddr, imem_ready,
    output pc, npc, imem_rd, fetch_valid, update_pending
  );

  modport master (
    output enable_updatePC, enable_fetch, br_taken, taddr, imem_ready,
    input  pc, npc, imem_rd, fetch_valid, update_pending
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch controller: owns the PC, sequences instruction-memory reads and
// buffers one PC redirect that arrives while a read is still outstanding.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clock,
  input  logic          reset,
  fetch_ctrl_if.slave   bus
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_target_q, pend_target_d;
  logic                pend_q, pend_d;

  logic                busy;
  logic [PC_WIDTH-1:0] base;
  logic [PC_WIDTH-1:0] target;

  // One target computation serves both the immediate and the buffered path;
  // a buffered redirect becomes the base for any later sequential step.
  always_comb begin
    busy   = (state_q == REQ) && !bus.imem_ready;
    base   = pend_q ? pend_target_q : pc_q;
    target = bus.br_taken ? bus.taddr : pc_inc(base);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.enable_fetch) state_d = REQ;
      REQ:  if (bus.imem_ready && !bus.enable_fetch) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // PC is frozen while a read is in flight; redirects seen then go to the slot.
  always_comb begin
    pc_d          = pc_q;
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
    if (busy) begin
      if (bus.enable_updatePC) begin
        pend_d        = 1'b1;
        pend_target_d = target;
      end
    end else begin
      pend_d = 1'b0;
      if (bus.enable_updatePC) pc_d = target;
      else if (pend_q)         pc_d = pend_target_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      pend_q        <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.npc            = pc_inc(pc_q);
  assign bus.imem_rd        = (state_q == REQ);
  assign bus.fetch_valid    = (state_q == REQ) && bus.imem_ready;
  assign bus.update_pending = pend_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written reset/redirect
// sequences, then random stimulus against a queue-based reference model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  fetch_ctrl_if bus();

  fetch_ctrl #(.RESET_PC(16'h3000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        upd;
    logic        fetch;
    logic        br;
    logic [15:0] taddr;
    logic        rdy;
    logic [15:0] e_pc;
    logic        e_rd;
    logic        e_fv;
    logic        e_pend;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic upd, logic fetch, logic br, logic [15:0] ta,
                              logic rdy, logic [15:0] epc, logic erd, logic efv,
                              logic epend);
    vec_t v;
    v.upd = upd; v.fetch = fetch; v.br = br; v.taddr = ta; v.rdy = rdy;
    v.e_pc = epc; v.e_rd = erd; v.e_fv = efv; v.e_pend = epend;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] epc, input logic erd,
                          input logic efv, input logic epend);
    logic [15:0] enpc;
    enpc = epc + 16'd1;
    chk({tag, ".pc"},             bus.pc,                    epc);
    chk({tag, ".npc"},            bus.npc,                   enpc);
    chk({tag, ".imem_rd"},        {15'd0, bus.imem_rd},      {15'd0, erd});
    chk({tag, ".fetch_valid"},    {15'd0, bus.fetch_valid},  {15'd0, efv});
    chk({tag, ".update_pending"}, {15'd0, bus.update_pending}, {15'd0, epend});
  endtask

  task automatic drive(input logic upd, input logic f, input logic br,
                       input logic [15:0] ta, input logic rdy);
    bus.enable_updatePC = upd;
    bus.enable_fetch    = f;
    bus.br_taken        = br;
    bus.taddr           = ta;
    bus.imem_ready      = rdy;
  endtask

  // Reference model: PC, whether a read is outstanding, and a redirect queue
  // holding at most one buffered target.
  logic [15:0] m_pc;
  bit          m_reading;
  logic [15:0] m_pend[$];

  task automatic model_reset();
    m_pc      = 16'h3000;
    m_reading = 0;
    m_pend.delete();
  endtask

  task automatic model_step(input logic upd, input logic f, input logic br,
                            input logic [15:0] ta, input logic rdy);
    logic [15:0] from, tgt;
    from = (m_pend.size() != 0) ? m_pend[0] : m_pc;
    tgt  = br ? ta : 16'(from + 16'd1);
    if (m_reading && !rdy) begin
      if (upd) begin
        m_pend.delete();
        m_pend.push_back(tgt);
      end
    end else begin
      if (upd) m_pc = tgt;
      else if (m_pend.size() != 0) m_pc = m_pend[0];
      m_pend.delete();
    end
    if (!m_reading) m_reading = f;
    else if (rdy)   m_reading = f;
  endtask

  initial begin
    logic [15:0] ta;
    logic u, f, b, r;

    drive(0, 0, 0, 16'h0, 0);
    repeat (2) @(negedge clock);
    chk_outs("reset", 16'h3000, 0, 0, 0);
    reset = 1'b0;

    // Directed table: expected values are the outputs before the edge.
    vecs.push_back(mk(1,1,0,16'h0000,1, 16'h3000,0,0,0));
    vecs.push_back(mk(1,1,0,16'h0000,1, 16'h3001,1,1,0));
    vecs.push_back(mk(1,1,0,16'h0000,1, 16'h3002,1,1,0));
    vecs.push_back(mk(0,1,0,16'h0000,0, 16'h3003,1,0,0));
    vecs.push_back(mk(1,1,1,16'h4000,0, 16'h3003,1,0,0));
    vecs.push_back(mk(0,1,0,16'h0000,0, 16'h3003,1,0,1));
    vecs.push_back(mk(1,1,0,16'h0000,0, 16'h3003,1,0,1));
    vecs.push_back(mk(0,1,0,16'h0000,1, 16'h3003,1,1,1));
    vecs.push_back(mk(1,0,1,16'h5000,1, 16'h4001,1,1,0));
    vecs.push_back(mk(0,0,1,16'h1234,1, 16'h5000,0,0,0));
    vecs.push_back(mk(1,0,1,16'hFFFF,0, 16'h5000,0,0,0));
    vecs.push_back(mk(1,0,0,16'h0000,0, 16'hFFFF,0,0,0));
    vecs.push_back(mk(0,0,0,16'h0000,0, 16'h0000,0,0,0));
    vecs.push_back(mk(0,1,0,16'h0000,0, 16'h0000,0,0,0));
    vecs.push_back(mk(1,1,1,16'h0100,0, 16'h0000,1,0,0));
    vecs.push_back(mk(1,1,0,16'h0000,1, 16'h0000,1,1,1));
    vecs.push_back(mk(0,0,0,16'h0000,1, 16'h0101,1,1,0));
    vecs.push_back(mk(0,0,0,16'h0000,0, 16'h0101,0,0,0));

    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].upd, vecs[i].fetch, vecs[i].br, vecs[i].taddr, vecs[i].rdy);
      #1 chk_outs($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_rd,
                  vecs[i].e_fv, vecs[i].e_pend);
    end

    // Asynchronous reset in the middle of a read with a redirect buffered.
    @(negedge clock); drive(0, 1, 0, 16'h0, 0);
    @(negedge clock); drive(1, 1, 1, 16'h4000, 0);
    @(negedge clock); drive(0, 1, 0, 16'h0, 1);
    #1 chk_outs("pre_rst", 16'h0101, 1, 1, 1);
    reset = 1'b1;
    #1 chk_outs("async_rst", 16'h3000, 0, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    drive(1, 1, 0, 16'h0, 0);
    #1 chk_outs("post_rst0", 16'h3000, 0, 0, 0);
    @(negedge clock); drive(0, 1, 0, 16'h0, 0);
    #1 chk_outs("post_rst1", 16'h3001, 1, 0, 0);

    // Random phase against the reference model.
    @(negedge clock);
    reset = 1'b1;
    drive(0, 0, 0, 16'h0, 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      u  = ($urandom_range(0, 9) < 4);
      f  = ($urandom_range(0, 9) < 7);
      b  = $urandom_range(0, 1) == 1;
      r  = $urandom_range(0, 1) == 1;
      ta = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      drive(u, f, b, ta, r);
      #1 chk_outs($sformatf("rnd%0d", i), m_pc, m_reading,
                  m_reading && r, m_pend.size() != 0);
      model_step(u, f, b, ta, r);
      @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
